rng_roller: RTL and testbench



---
 rtl/rng_roller.sv | 179 +++++++++++++++++
 tb/tb_rng_roller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_roller.sv
// rng_roller: decelerating dice roller with a browsable result history.
// Sits between the debounced keys and the 7-segment decoder.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_start        start/stop key (level, edge-detected here)
//   i_show_last_n  low = browse history while idle
//   i_hist_sel     history index, 0 = newest
//   i_pause        (RNG_ROLLER_PAUSE_EN only) freeze a running roll
//   o_random_out   registered display value
//   o_changing     high while rolling
//   o_done         one-cycle pulse when a result is committed
//   o_hist_count   valid history entries, saturating at HIST_DEPTH
//
// Optional feature macro: RNG_ROLLER_PAUSE_EN adds i_pause.
module rng_roller #(
  parameter int OUT_W      = 4,
  parameter int STEPS      = 16,
  parameter int BASE_DLY   = 2097152,
  parameter int HIST_DEPTH = 4,
  localparam int HSEL_W =
    (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1,
  localparam int HCNT_W = $clog2(HIST_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_show_last_n,
  input  logic [HSEL_W-1:0] i_hist_sel,
`ifdef RNG_ROLLER_PAUSE_EN
  input  logic              i_pause,
`endif
  output logic [OUT_W-1:0]  o_random_out,
  output logic              o_changing,
  output logic              o_done,
  output logic [HCNT_W-1:0] o_hist_count
);

  // thr must hold STEPS*BASE_DLY, the longest interval
  localparam logic [63:0] THR_MAX =
    64'(STEPS) * 64'(BASE_DLY);
  localparam int THR_W  = $clog2(THR_MAX + 64'd1);
  localparam int STEP_W = $clog2(STEPS);

  localparam logic [THR_W-1:0]  BASE = THR_W'(BASE_DLY);
  localparam logic [THR_W-1:0]  T_ONE = THR_W'(1);
  localparam logic [STEP_W-1:0] S_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);
  localparam logic [HCNT_W-1:0] H_ONE = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] H_MAX =
    HCNT_W'(HIST_DEPTH);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic {
    IDLE,
    ROLL
  } state_t;

  state_t              state;
  logic [31:0]         free_cnt;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_nxt;
  logic [THR_W-1:0]    dly_cnt;
  logic [THR_W-1:0]    thr;
  logic [STEP_W-1:0]   step;
  logic                start_q;
  logic [OUT_W-1:0]    hist [HIST_DEPTH];

  logic                start_ev;
  logic                hold;
  logic                abort;
  logic                tick;
  logic                last;
  logic                commit;
  logic [OUT_W-1:0]    commit_val;
  logic [OUT_W-1:0]    sel_val;

`ifdef RNG_ROLLER_PAUSE_EN
  assign hold = i_pause;
`else
  assign hold = 1'b0;
`endif

  assign start_ev = i_start & ~start_q;

  assign lfsr_nxt = {1'b0, lfsr[31:1]}
                  ^ (lfsr[0] ? TAPS : 32'h0);

  // abort beats a coincident interval update
  assign abort = (state == ROLL) && start_ev;

  assign tick = (state == ROLL) && !start_ev
             && !hold && (dly_cnt == thr - T_ONE);

  assign last = tick && (step == LAST);

  assign commit = abort | last;

  assign commit_val = abort ? o_random_out
                            : lfsr_nxt[OUT_W-1:0];

  assign o_changing = (state == ROLL);

  // idle display source; out-of-range index shows 0
  always_comb begin
    sel_val = hist[0];
    if (!i_show_last_n) begin
      if (HCNT_W'(i_hist_sel) < o_hist_count)
        sel_val = hist[i_hist_sel];
      else
        sel_val = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      free_cnt     <= '0;
      lfsr         <= '0;
      dly_cnt      <= '0;
      thr          <= '0;
      step         <= '0;
      start_q      <= 1'b0;
      o_random_out <= '0;
      o_done       <= 1'b0;
      o_hist_count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++)
        hist[i] <= '0;
    end else begin
      free_cnt <= free_cnt + 32'd1;
      start_q  <= i_start;
      o_done   <= commit;

      if (commit) begin
        hist[0] <= commit_val;
        for (int i = 1; i < HIST_DEPTH; i++)
          hist[i] <= hist[i-1];
        if (o_hist_count != H_MAX)
          o_hist_count <= o_hist_count + H_ONE;
      end

      unique case (state)
        IDLE: begin
          if (start_ev) begin
            // OR-ing bit 0 keeps the LFSR out of
            // its all-zero lock-up state
            lfsr    <= free_cnt | 32'h1;
            step    <= '0;
            dly_cnt <= '0;
            thr     <= BASE;
            state   <= ROLL;
          end else begin
            o_random_out <= sel_val;
          end
        end
        ROLL: begin
          if (abort) begin
            state <= IDLE;
          end else if (!hold) begin
            if (tick) begin
              lfsr         <= lfsr_nxt;
              o_random_out <= lfsr_nxt[OUT_W-1:0];
              dly_cnt      <= '0;
              thr          <= thr + BASE;
              step         <= step + S_ONE;
              if (last)
                state <= IDLE;
            end else begin
              dly_cnt <= dly_cnt + T_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_roller.sv
// tb_rng_roller: scoreboard bench for rng_roller.
// Stimulus queues expectations, a negedge monitor checks them.
module tb_rng_roller;

  localparam int OUT_W      = 4;
  localparam int STEPS      = 4;
  localparam int BASE_DLY   = 4;
  localparam int HIST_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       show_n = 1'b1;
  logic [1:0] hsel = 2'd0;
  logic       pause = 1'b0;
  logic [3:0] rout;
  logic       chg;
  logic       done;
  logic [2:0] hcnt;

  always #5 clk = ~clk;

  rng_roller #(
    .OUT_W(OUT_W),
    .STEPS(STEPS),
    .BASE_DLY(BASE_DLY),
    .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_show_last_n(show_n),
    .i_hist_sel(hsel),
`ifdef RNG_ROLLER_PAUSE_EN
    .i_pause(pause),
`endif
    .o_random_out(rout),
    .o_changing(chg),
    .o_done(done),
    .o_hist_count(hcnt)
  );

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } upd_t;

  typedef struct {
    logic [3:0] val;
    logic [2:0] cnt;
  } done_t;

  upd_t       upd_q[$];
  done_t      done_q[$];
  logic [3:0] hist_m[$];

  int checks = 0;
  int passes = 0;

  int unsigned cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] lstep(
    input logic [31:0] l);
    return {1'b0, l[31:1]}
         ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // monitor
  logic       prev_ch = 1'b0;
  logic [3:0] prev_out = 4'd0;
  int         rc = 0;

  initial begin
    upd_t  u;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ch = 1'b0;
      end else begin
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 0);
          end else begin
            d = done_q.pop_front();
            chk("done_val", 32'(rout), 32'(d.val));
            chk("done_cnt", 32'(hcnt), 32'(d.cnt));
          end
        end
        if (chg && !prev_ch) begin
          rc = 0;
          chk("start_hold", 32'(rout), 32'(prev_out));
        end else if (prev_ch) begin
          rc++;
          if (upd_q.size() > 0 && upd_q[0].cyc == rc) begin
            u = upd_q.pop_front();
            chk($sformatf("upd_val@%0d", rc),
                32'(rout), 32'(u.val));
          end else begin
            chk($sformatf("roll_hold@%0d", rc),
                32'(rout), 32'(prev_out));
          end
        end
      end
      prev_ch  = chg;
      prev_out = rout;
    end
  end

  task automatic expect_commit(input logic [3:0] v);
    hist_m.push_front(v);
    if (hist_m.size() > HIST_DEPTH) void'(hist_m.pop_back());
    done_q.push_back('{v, 3'(hist_m.size())});
  endtask

  // One roll. at_cyc<0: start at next negedge.
  // abort_at>0: second start edge at that roll cycle.
  // hold_len: cycles i_start stays high.
  task automatic roll(input int at_cyc,
                      input int abort_at,
                      input int hold_len,
                      input int p_at,
                      input int p_len,
                      output logic [3:0] res);
    logic [31:0] l;
    int c, cc;
    bit ok;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (at_cyc < 0 || cyc == 32'(at_cyc)) break;
    end
    l = cyc | 32'h1;
    start = 1'b1;
    c = 0;
    res = rout;
    for (int k = 1; k <= STEPS; k++) begin
      c += k * BASE_DLY;
      l = lstep(l);
      cc = c + ((p_len > 0 && c >= p_at) ? p_len : 0);
      if (abort_at == 0 || cc < abort_at) begin
        upd_q.push_back('{cc, l[3:0]});
        res = l[3:0];
      end
    end
    expect_commit(res);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k + 1 >= hold_len) start = 1'b0;
      if (abort_at > 0 && k + 1 == abort_at) start = 1'b1;
      if (p_len > 0 && k + 1 == p_at) pause = 1'b1;
      if (p_len > 0 && k + 1 == p_at + p_len) pause = 1'b0;
      if (!chg && !start && !pause) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL roll_timeout: changing=%0b want 0", chg);
      start = 1'b0;
      pause = 1'b0;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out"},  32'(rout), 0);
    chk({tag, "_chg"},  32'(chg),  0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cnt"},  32'(hcnt), 0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [3:0] res_a, res_b, res_c, res_d, res_e, res_f;
    logic [31:0] l;

    // async reset before any clock edge
    #2 rst_n = 1'b0;
    #1 reset_checks("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // full roll seeded from free_cnt=100 -> 101
    roll(100, 0, 1, 0, 0, res_a);
    settle();
    chk("rollA_newest", 32'(rout), 32'h7);
    chk("rollA_cnt", 32'(hcnt), 1);

    // abort after 10 roll cycles
    roll(-1, 10, 1, 0, 0, res_b);
    settle();
    chk("rollB_newest", 32'(rout), 32'(res_b));
    chk("rollB_chg", 32'(chg), 0);

    // key held 200 cycles: one roll only
    roll(-1, 0, 200, 0, 0, res_c);
    settle();
    chk("rollC_cnt", 32'(hcnt), 3);

    roll(-1, 0, 1, 0, 0, res_d);
    roll(-1, 0, 1, 0, 0, res_e);
    settle();
    chk("sat_cnt", 32'(hcnt), 4);
    chk("newest_e", 32'(rout), 32'(res_e));

    show_n = 1'b0;
    hsel = 2'd3;
    settle();
    chk("hist_sel3", 32'(rout), 32'(res_b));
    hsel = 2'd1;
    settle();
    chk("hist_sel1", 32'(rout), 32'(res_d));
    show_n = 1'b1;
    hsel = 2'd0;
    settle();

    // reset in the middle of a roll
    @(negedge clk);
    l = cyc | 32'h1;
    start = 1'b1;
    l = lstep(l);
    upd_q.push_back('{4, l[3:0]});
    l = lstep(l);
    upd_q.push_back('{12, l[3:0]});
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midroll_chg", 32'(chg), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    upd_q.delete();
    done_q.delete();
    hist_m.delete();
    #1 reset_checks("rst_roll");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // one roll after reset
    roll(-1, 0, 1, 0, 0, res_f);
    settle();
    chk("post_rst_cnt", 32'(hcnt), 1);
    show_n = 1'b0;
    hsel = 2'd2;
    settle();
    chk("hist_sel2_empty", 32'(rout), 0);
    hsel = 2'd0;
    settle();
    chk("hist_sel0", 32'(rout), 32'(res_f));
    show_n = 1'b1;
    settle();
    chk("show_last", 32'(rout), 32'(res_f));

`ifdef RNG_ROLLER_PAUSE_EN
    begin
      logic [3:0] res_g;
      roll(-1, 0, 1, 2, 50, res_g);
      settle();
      chk("pause_final", 32'(rout), 32'(res_g));
    end
`endif

    repeat (3) @(negedge clk);
    chk("upd_q_empty", upd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
